vram_arbiter: RTL
=================

# vram_arbiter

Arbitrates a single-port synchronous on-chip VRAM between two requesters: the VGA scanout fetch engine (hard real-time, default priority) and the Nios II CPU through an Avalon-MM slave (best-effort, stalled with waitrequest). It sits inside the VGA text-mode peripheral, between the Avalon slave interface and the VRAM macro. It issues at most one RAM command per cycle, routes read data back to the right requester, and optionally bounds CPU starvation.

## Interface
- ADDR_W, 10, VRAM word address width
- DATA_W, 32, VRAM word width; byte-enable width is DATA_W/8
- STARVE_MAX, 8, consecutive denied CPU-pending cycles before the CPU is forced to win (guard builds only)
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- avl_read  in  1  CPU read request
- avl_write  in  1  CPU write request
- avl_address  in  ADDR_W  CPU word address
- avl_writedata  in  DATA_W  CPU write data
- avl_byteenable  in  DATA_W/8  CPU write byte enables
- avl_readdata  out  DATA_W  CPU read data, valid when avl_waitrequest is low on a read
- avl_waitrequest  out  1  stall to CPU; high whenever no completion is occurring
- vga_req  in  1  scanout read request
- vga_addr  in  ADDR_W  scanout word address
- vga_gnt  out  1  combinational; request accepted this cycle
- vga_rvalid  out  1  scanout read data valid
- vga_rdata  out  DATA_W  scanout read data
- ram_addr, ram_wdata, ram_be, ram_we  out  ADDR_W / DATA_W / DATA_W/8 / 1  registered RAM command
- ram_rdata  in  DATA_W  RAM read data, one cycle after the command is presented

## Operation
- States: IDLE, CPU_RD_WAIT, CPU_DONE. VGA reads are accepted in every state.
- Arbitration runs each cycle over the eligible requesters. The CPU is eligible only in IDLE with avl_read or avl_write high.
- Default winner is VGA. The CPU wins when VGA is idle, or when the starvation guard fires.
- VGA win: vga_gnt=1. The command is registered into ram_*, and a VGA tag enters the 2-stage return pipe.
- CPU write win: ram_we=1 with address, data and byte enables registered. Go to CPU_DONE.
- CPU read win: the read command is registered and a CPU tag enters the return pipe. Go to CPU_RD_WAIT.
- CPU_RD_WAIT: when the CPU tag exits the pipe, avl_readdata takes ram_rdata (registered) and the state goes to CPU_DONE.
- CPU_DONE: avl_waitrequest=0 for exactly one cycle, then IDLE.
- avl_read and avl_write both high: treated as a write.
- avl_byteenable is ignored on reads. ram_be is all ones on reads.
- VGA returns are strictly in request order.
- The return pipe holds at most 2 tags and never back-pressures.

## Timing
- VGA: request accepted in cycle N; vga_rvalid=1 with data in cycle N+2. Full throughput is one read per cycle.
- CPU write: granted in cycle N; RAM written at the end of N+1; waitrequest low in N+1 (latency 2 from first request cycle, absent contention).
- CPU read: granted in cycle N; waitrequest low with valid readdata in N+3.
- While the CPU is in CPU_RD_WAIT or CPU_DONE, the held Avalon request must not be re-granted.
- Reset values: avl_waitrequest=1, avl_readdata=0, vga_gnt=0, vga_rvalid=0, vga_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0, ram_be=0, state IDLE, starvation counter 0, return pipe empty.
- Reset mid-transfer: in-flight tags are discarded; no completion pulse is emitted after release.

## Configuration
- VRAM_ARB_STARVE_GUARD_EN defined:
  - A counter increments each cycle the CPU is eligible but loses, and saturates at STARVE_MAX.
  - At STARVE_MAX the CPU wins the next arbitration even if vga_req=1, and vga_gnt=0 that cycle.
  - The counter clears on any CPU grant.
- Undefined: strict VGA priority. A CPU request may wait indefinitely under continuous vga_req. STARVE_MAX is unused.

## Structure
- Package vram_arb_pkg holds:
  - the state enum (IDLE, CPU_RD_WAIT, CPU_DONE)
  - the return-tag enum (NONE, VGA, CPU)
  - localparam BE_W = DATA_W/8 helper
- One sub-module, vram_arb_ret_pipe: a 2-stage tag shift register that steers ram_rdata to the VGA or CPU path.

## Test plan
- VGA reads addresses 0..7 back-to-back from a preloaded RAM (word k = 0xA5000000+k) -> vga_rvalid high for 8 consecutive cycles starting 2 cycles after the first request, data in order.
- CPU writes 0xDEADBEEF with byteenable 4'b0011 to address 0x010 (old value 0x12345678), then reads it back -> readback 0x1234BEEF; waitrequest low 1 cycle for the write and 1 cycle for the read.
- CPU read issued while VGA idles, then VGA starts requesting in CPU_RD_WAIT -> VGA granted every cycle, CPU completes at N+3 with the correct data.
- Continuous vga_req with the CPU pending and the guard enabled (STARVE_MAX=8) -> vga_gnt drops for exactly one cycle after 8 denied cycles and the CPU completes. Guard disabled -> the CPU stays stalled for the whole 100-cycle window.
- reset_reset_n asserted during CPU_RD_WAIT -> all outputs at reset values immediately; no vga_rvalid or waitrequest-low pulse after release.
- avl_read and avl_write asserted together -> a write is performed and RAM content updates.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: FSM states, return-pipe tags and
// byte-enable width helper.
package vram_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int BE_W       = DEF_DATA_W / 8;

    // CPU-side transaction progress; VGA traffic is stateless.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CPU_RD_WAIT = 2'd1,
        CPU_DONE    = 2'd2
    } arb_state_e;

    // Owner of the read data returning from the RAM.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_CPU  = 2'd2
    } ret_tag_e;

endpackage

// File: rtl/vram_arb_ret_pipe.sv
// Two-stage tag shift register tracking who owns each RAM read in flight.
// A tag pushed with the registered command reaches stage 1 exactly when the
// RAM presents the matching read data, so the data is steered combinationally.
module vram_arb_ret_pipe
    import vram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  ret_tag_e          tag_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              vga_rvalid_o,
    output logic [DATA_W-1:0] vga_rdata_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o
);

    ret_tag_e stage0_q;
    ret_tag_e stage1_q;

    // Advance the tags one stage per cycle; reset discards reads in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage0_q <= TAG_NONE;
            stage1_q <= TAG_NONE;
        end else begin
            // NOTE: non-blocking so stage1 takes the old stage0, giving a true shift.
            stage0_q <= tag_i;
            stage1_q <= stage0_q;
        end
    end

    assign vga_rvalid_o = (stage1_q == TAG_VGA);
    assign vga_rdata_o  = vga_rvalid_o ? ram_rdata_i : '0;
    assign cpu_rvalid_o = (stage1_q == TAG_CPU);
    assign cpu_rdata_o  = ram_rdata_i;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between VGA scanout (default priority) and the
// CPU Avalon-MM slave (stalled with waitrequest). One RAM command per cycle.
// Optional starvation bound on the CPU: define VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                avl_read,
    input  logic                avl_write,
    input  logic [ADDR_W-1:0]   avl_address,
    input  logic [DATA_W-1:0]   avl_writedata,
    input  logic [DATA_W/8-1:0] avl_byteenable,
    output logic [DATA_W-1:0]   avl_readdata,
    output logic                avl_waitrequest,
    input  logic                vga_req,
    input  logic [ADDR_W-1:0]   vga_addr,
    output logic                vga_gnt,
    output logic                vga_rvalid,
    output logic [DATA_W-1:0]   vga_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_be,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_rdata
);

    arb_state_e          state_q, state_d;
    logic                run_q;
    logic                waitreq_q, waitreq_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_W/8-1:0] ram_be_q, ram_be_d;
    logic                ram_we_q, ram_we_d;
    ret_tag_e            push_tag;

    logic                cpu_elig;
    logic                cpu_win;
    logic                vga_win;
    logic                cpu_rvalid;
    logic [DATA_W-1:0]   cpu_rdata;

    // The CPU can only compete while no transaction of its own is in progress.
    assign cpu_elig = run_q && (state_q == IDLE) && (avl_read || avl_write);

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int                  STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_q, starve_d;

    assign cpu_win  = cpu_elig && (!vga_req || (starve_q == STARVE_LIM));
    assign starve_d = cpu_win                                 ? '0 :
                      (cpu_elig && (starve_q != STARVE_LIM)) ? starve_q + 1'b1 :
                                                               starve_q;

    // Count consecutive lost arbitrations; saturating, cleared by a CPU grant.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict VGA priority: the starvation limit has no effect in this build.
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX != 0);
    assign cpu_win           = cpu_elig && !vga_req;
`endif

    // VGA is refused only in the first cycle after reset or when the CPU is forced in.
    assign vga_win = vga_req && run_q && !cpu_win;
    assign vga_gnt = vga_win;

    // Next RAM command and CPU transaction progress.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d     = state_q;
        waitreq_d   = 1'b1;
        rdata_d     = rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_be_d    = ram_be_q;
        ram_we_d    = 1'b0;
        push_tag    = TAG_NONE;

        if (vga_win) begin
            ram_addr_d = vga_addr;
            ram_be_d   = '1;
            push_tag   = TAG_VGA;
        end else if (cpu_win) begin
            ram_addr_d = avl_address;
            if (avl_write) begin
                // Simultaneous read and write resolves to a write.
                ram_we_d    = 1'b1;
                ram_wdata_d = avl_writedata;
                ram_be_d    = avl_byteenable;
                state_d     = CPU_DONE;
                waitreq_d   = 1'b0;
            end else begin
                ram_be_d = '1;
                push_tag = TAG_CPU;
                state_d  = CPU_RD_WAIT;
            end
        end

        case (state_q)
            CPU_RD_WAIT: begin
                if (cpu_rvalid) begin
                    rdata_d   = cpu_rdata;
                    state_d   = CPU_DONE;
                    waitreq_d = 1'b0;
                end
            end
            CPU_DONE: state_d = IDLE;
            default:  ;
        endcase
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            waitreq_q   <= 1'b1;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_be_q    <= '0;
            ram_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            // NOTE: run_q keeps the combinational grant low while reset is held.
            run_q       <= 1'b1;
            waitreq_q   <= waitreq_d;
            rdata_q     <= rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_be_q    <= ram_be_d;
            ram_we_q    <= ram_we_d;
        end
    end

    assign avl_waitrequest = waitreq_q;
    assign avl_readdata    = rdata_q;
    assign ram_addr        = ram_addr_q;
    assign ram_wdata       = ram_wdata_q;
    assign ram_be          = ram_be_q;
    assign ram_we          = ram_we_q;

    vram_arb_ret_pipe #(
        .DATA_W (DATA_W)
    ) u_ret_pipe (
        .clk_i        (clk_clk),
        .rst_ni       (reset_reset_n),
        .tag_i        (push_tag),
        .ram_rdata_i  (ram_rdata),
        .vga_rvalid_o (vga_rvalid),
        .vga_rdata_o  (vga_rdata),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_rdata_o  (cpu_rdata)
    );

endmodule
